// File: rtl/game_round_scheduler_if.sv
// Player-side handshake and display-side game-state bundle for game_round_scheduler.
interface game_round_scheduler_if;
  localparam int unsigned CELL_W  = 9;
  localparam int unsigned LIFE_W  = 3;
  localparam int unsigned SCORE_W = 4;

  logic                start;
  logic [CELL_W-1:0]   box;
  logic [1:0]          game_state;
  logic [CELL_W-1:0]   fire_state;
  logic [CELL_W-1:0]   gold_state;
  logic [CELL_W-1:0]   next_fire_pattern;
  logic [CELL_W-1:0]   hit_bitmap;
  logic [LIFE_W-1:0]   life;
  logic [SCORE_W-1:0]  score;
  logic                win;

  modport master (
    output start, box,
    input  game_state, fire_state, gold_state, next_fire_pattern, hit_bitmap, life, score, win
  );

  modport slave (
    input  start, box,
    output game_state, fire_state, gold_state, next_fire_pattern, hit_bitmap, life, score, win
  );
endinterface

// File: rtl/game_round_scheduler.sv
// Game sequencer: INIT -> WARN/FIRE rounds -> FINISH, with LFSR fire patterns,
// gold placement and life/score bookkeeping for the display controller.
module game_round_scheduler #(
  parameter int unsigned TICK_DIV   = 50_000_000,
  parameter int unsigned WARN_TICKS = 2,
  parameter int unsigned FIRE_TICKS = 2,
  parameter int unsigned LIFE_MAX   = 5,
  parameter int unsigned SCORE_MAX  = 3,
  parameter logic [8:0]  SEED       = 9'h001
) (
  input logic                   clk,
  input logic                   rst,
  game_round_scheduler_if.slave bus
);
  localparam int unsigned CELL_W    = 9;
  localparam int unsigned LIFE_W    = 3;
  localparam int unsigned SCORE_W   = 4;
  localparam int unsigned TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned PHASE_MAX = (WARN_TICKS > FIRE_TICKS) ? WARN_TICKS : FIRE_TICKS;
  localparam int unsigned PHASE_W   = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;

  localparam logic [CELL_W-1:0]  SEED_EFF  = (SEED == '0) ? CELL_W'(1) : SEED;
  localparam logic [CELL_W-1:0]  ALL_BURN  = '1;
  localparam logic [CELL_W-1:0]  SAFE_PAT  = 9'h1EF;
  localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [PHASE_W-1:0] WARN_LAST = PHASE_W'(WARN_TICKS - 1);
  localparam logic [PHASE_W-1:0] FIRE_LAST = PHASE_W'(FIRE_TICKS - 1);
  localparam logic [LIFE_W-1:0]  LIFE_INIT = LIFE_W'(LIFE_MAX);
  localparam logic [SCORE_W-1:0] SCORE_WIN = SCORE_W'(SCORE_MAX);

  typedef enum logic [1:0] {S_INIT, S_WARN, S_FIRE, S_FINISH} state_t;

  // Never let every cell burn: one cell stays safe.
  function automatic logic [CELL_W-1:0] safe_pat(input logic [CELL_W-1:0] x);
    return (x == ALL_BURN) ? SAFE_PAT : x;
  endfunction

  // Gold goes on the lowest-index cell that is not burning.
  function automatic logic [CELL_W-1:0] gold_of(input logic [CELL_W-1:0] p);
    logic [CELL_W-1:0] g;
    g = '0;
    for (int i = int'(CELL_W) - 1; i >= 0; i--) begin
      if (!p[i]) g = CELL_W'(1) << i;
    end
    return g;
  endfunction

  function automatic logic [CELL_W-1:0] lfsr_step(input logic [CELL_W-1:0] x);
    return {x[7:0], x[8] ^ x[4]};
  endfunction

  state_t              state_q, state_n;
  logic [1:0]          game_state_q, game_state_n;
  logic [CELL_W-1:0]   lfsr_q, lfsr_n;
  logic [TICK_W-1:0]   tick_q, tick_n;
  logic [PHASE_W-1:0]  phase_q, phase_n;
  logic                round_hit_q, round_hit_n;
  logic [CELL_W-1:0]   fire_q, fire_n;
  logic [CELL_W-1:0]   gold_q, gold_n;
  logic [CELL_W-1:0]   nfp_q, nfp_n;
  logic [CELL_W-1:0]   hit_q, hit_n;
  logic [LIFE_W-1:0]   life_q, life_n;
  logic [SCORE_W-1:0]  score_q, score_n;
  logic                win_q, win_n;
  logic                tick;
  logic [CELL_W-1:0]   burn;
  logic [CELL_W-1:0]   grab;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_INIT;
      game_state_q <= 2'b00;
      lfsr_q       <= SEED_EFF;
      tick_q       <= '0;
      phase_q      <= '0;
      round_hit_q  <= 1'b0;
      fire_q       <= '0;
      gold_q       <= '0;
      nfp_q        <= '0;
      hit_q        <= '0;
      life_q       <= LIFE_INIT;
      score_q      <= '0;
      win_q        <= 1'b0;
    end else begin
      state_q      <= state_n;
      game_state_q <= game_state_n;
      lfsr_q       <= lfsr_n;
      tick_q       <= tick_n;
      phase_q      <= phase_n;
      round_hit_q  <= round_hit_n;
      fire_q       <= fire_n;
      gold_q       <= gold_n;
      nfp_q        <= nfp_n;
      hit_q        <= hit_n;
      life_q       <= life_n;
      score_q      <= score_n;
      win_q        <= win_n;
    end
  end

  always_comb begin
    state_n     = state_q;
    lfsr_n      = lfsr_q;
    tick_n      = tick_q;
    phase_n     = phase_q;
    round_hit_n = round_hit_q;
    fire_n      = fire_q;
    gold_n      = gold_q;
    nfp_n       = nfp_q;
    hit_n       = hit_q;
    life_n      = life_q;
    score_n     = score_q;
    win_n       = win_q;
    tick        = (tick_q == TICK_LAST);
    burn        = bus.box & fire_q;
    grab        = bus.box & gold_q;

    case (state_q)
      S_INIT: begin
        if (bus.start) begin
          nfp_n   = safe_pat(lfsr_q);
          gold_n  = gold_of(safe_pat(lfsr_q));
          lfsr_n  = lfsr_step(lfsr_q);
          tick_n  = '0;
          phase_n = '0;
          state_n = S_WARN;
        end
      end
      S_WARN, S_FIRE: begin
        tick_n = tick ? '0 : tick_q + TICK_W'(1);
        if (tick) phase_n = phase_q + PHASE_W'(1);
        if (grab != '0) begin
          gold_n = '0;
          if (score_q != SCORE_WIN) score_n = score_q + SCORE_W'(1);
        end
        if (state_q == S_WARN) begin
          if (tick && (phase_q == WARN_LAST)) begin
            fire_n  = nfp_q;
            nfp_n   = safe_pat(lfsr_q);
            lfsr_n  = lfsr_step(lfsr_q);
            tick_n  = '0;
            phase_n = '0;
            state_n = S_FIRE;
          end
        end else begin
          hit_n = hit_q | burn;
          if ((burn != '0) && !round_hit_q) begin
            life_n      = life_q - LIFE_W'(1);
            round_hit_n = 1'b1;
          end
          if (tick && (phase_q == FIRE_LAST)) begin
            fire_n      = '0;
            hit_n       = '0;
            round_hit_n = 1'b0;
            gold_n      = gold_of(nfp_q);
            tick_n      = '0;
            phase_n     = '0;
            state_n     = S_WARN;
          end
        end
        // Game end beats any phase change; losing wins ties with a winning score.
        if ((life_n == '0) || (score_n == SCORE_WIN)) begin
          state_n     = S_FINISH;
          win_n       = (life_n != '0);
          lfsr_n      = lfsr_q;
          fire_n      = '0;
          gold_n      = '0;
          nfp_n       = '0;
          hit_n       = '0;
          round_hit_n = 1'b0;
          tick_n      = '0;
          phase_n     = '0;
        end
      end
      S_FINISH: begin
        if (bus.start) begin
          state_n = S_INIT;
          life_n  = LIFE_INIT;
          score_n = '0;
          win_n   = 1'b0;
        end
      end
      default: state_n = S_INIT;
    endcase

    case (state_n)
      S_INIT:         game_state_n = 2'b00;
      S_WARN, S_FIRE: game_state_n = 2'b01;
      S_FINISH:       game_state_n = 2'b10;
      default:        game_state_n = 2'b00;
    endcase
  end

  assign bus.game_state        = game_state_q;
  assign bus.fire_state        = fire_q;
  assign bus.gold_state        = gold_q;
  assign bus.next_fire_pattern = nfp_q;
  assign bus.hit_bitmap        = hit_q;
  assign bus.life              = life_q;
  assign bus.score             = score_q;
  assign bus.win               = win_q;
endmodule

// File: tb/tb_game_round_scheduler.sv
// Scoreboard bench for game_round_scheduler: per-cycle expected snapshots are queued
// with the stimulus and compared one clock later. Two instances cover LIFE_MAX 5 and 1.
module tb_game_round_scheduler;
  typedef struct packed {
    logic [1:0] gs;
    logic [8:0] fire;
    logic [8:0] gold;
    logic [8:0] nfp;
    logic [8:0] hit;
    logic [2:0] life;
    logic [3:0] score;
    logic       win;
  } snap_t;

  logic  clk = 1'b0;
  logic  rst_a;
  logic  rst_b;
  logic  sel_b;
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc_no   = 0;
  snap_t want_s;
  snap_t sb_q[$];

  always #5 clk = ~clk;

  game_round_scheduler_if ifa ();
  game_round_scheduler_if ifb ();

  game_round_scheduler #(
    .TICK_DIV(4), .WARN_TICKS(2), .FIRE_TICKS(2),
    .LIFE_MAX(5), .SCORE_MAX(3), .SEED(9'h001)
  ) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (ifa.slave)
  );

  game_round_scheduler #(
    .TICK_DIV(4), .WARN_TICKS(2), .FIRE_TICKS(2),
    .LIFE_MAX(1), .SCORE_MAX(3), .SEED(9'h001)
  ) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (ifb.slave)
  );

  task automatic check_eq(input string tag, input logic [8:0] got, input logic [8:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  function automatic snap_t grab_out(input logic b);
    if (b)
      return {ifb.game_state, ifb.fire_state, ifb.gold_state, ifb.next_fire_pattern,
              ifb.hit_bitmap, ifb.life, ifb.score, ifb.win};
    return {ifa.game_state, ifa.fire_state, ifa.gold_state, ifa.next_fire_pattern,
            ifa.hit_bitmap, ifa.life, ifa.score, ifa.win};
  endfunction

  // Drive one cycle of stimulus on the selected instance and queue the expected result.
  task automatic cyc(input logic r, input logic s, input logic [8:0] b);
    snap_t got;
    snap_t want;
    string pfx;
    if (sel_b) begin
      rst_b = r; ifb.start = s; ifb.box = b;
    end else begin
      rst_a = r; ifa.start = s; ifa.box = b;
    end
    sb_q.push_back(want_s);
    @(posedge clk);
    #1;
    cyc_no++;
    got  = grab_out(sel_b);
    want = sb_q.pop_front();
    pfx  = $sformatf("%s c%0d", sel_b ? "B" : "A", cyc_no);
    check_eq({pfx, " game_state"}, 9'(got.gs),    9'(want.gs));
    check_eq({pfx, " fire_state"}, got.fire,      want.fire);
    check_eq({pfx, " gold_state"}, got.gold,      want.gold);
    check_eq({pfx, " next_fire"},  got.nfp,       want.nfp);
    check_eq({pfx, " hit_bitmap"}, got.hit,       want.hit);
    check_eq({pfx, " life"},       9'(got.life),  9'(want.life));
    check_eq({pfx, " score"},      9'(got.score), 9'(want.score));
    check_eq({pfx, " win"},        9'(got.win),   9'(want.win));
  endtask

  task automatic hold(input int n, input logic [8:0] b);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, b);
  endtask

  task automatic rst_exp(input logic [2:0] l);
    want_s      = '0;
    want_s.life = l;
  endtask

  // Reset, start, then collect the round-1 gold (002) and round-2 gold (001)
  // while dodging fire; ends on the cycle round 3 WARN begins (gold 001).
  task automatic two_gold_rounds(input logic [2:0] l);
    rst_exp(l);
    cyc(1'b1, 1'b0, 9'h000);
    want_s.gs = 2'b01; want_s.nfp = 9'h001; want_s.gold = 9'h002;
    cyc(1'b0, 1'b1, 9'h000);
    want_s.score = 4'd1; want_s.gold = 9'h000;
    cyc(1'b0, 1'b0, 9'h002);
    hold(6, 9'h000);
    want_s.fire = 9'h001; want_s.nfp = 9'h002;
    cyc(1'b0, 1'b0, 9'h000);
    hold(7, 9'h000);
    want_s.fire = 9'h000; want_s.gold = 9'h001;
    cyc(1'b0, 1'b0, 9'h000);
    want_s.score = 4'd2; want_s.gold = 9'h000;
    cyc(1'b0, 1'b0, 9'h001);
    hold(6, 9'h000);
    want_s.fire = 9'h002; want_s.nfp = 9'h004;
    cyc(1'b0, 1'b0, 9'h000);
    hold(7, 9'h000);
    want_s.fire = 9'h000; want_s.gold = 9'h001;
    cyc(1'b0, 1'b0, 9'h000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t, limit 200000", $time);
    $fatal(1);
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; sel_b = 1'b0;
    ifa.start = 1'b0; ifa.box = '0;
    ifb.start = 1'b0; ifb.box = '0;
    @(posedge clk);
    #1;

    // Reset values, then INIT holds without start.
    rst_exp(3'd5);
    cyc(1'b1, 1'b0, 9'h000);
    cyc(1'b1, 1'b0, 9'h000);
    hold(20, 9'h000);

    // Round timing and a single life loss while standing in fire.
    want_s.gs = 2'b01; want_s.nfp = 9'h001; want_s.gold = 9'h002;
    cyc(1'b0, 1'b1, 9'h000);
    hold(7, 9'h000);
    want_s.fire = 9'h001; want_s.nfp = 9'h002;
    cyc(1'b0, 1'b0, 9'h001);
    want_s.life = 3'd4; want_s.hit = 9'h001;
    cyc(1'b0, 1'b0, 9'h001);
    hold(2, 9'h001);
    cyc(1'b0, 1'b1, 9'h001);
    hold(3, 9'h001);
    want_s.fire = 9'h000; want_s.hit = 9'h000; want_s.gold = 9'h001;
    cyc(1'b0, 1'b0, 9'h001);
    hold(3, 9'h000);

    // Gold pickup in first WARN, then rst in the middle of FIRE.
    rst_exp(3'd5);
    cyc(1'b1, 1'b0, 9'h000);
    want_s.gs = 2'b01; want_s.nfp = 9'h001; want_s.gold = 9'h002;
    cyc(1'b0, 1'b1, 9'h000);
    want_s.score = 4'd1; want_s.gold = 9'h000;
    cyc(1'b0, 1'b0, 9'h002);
    hold(6, 9'h002);
    want_s.fire = 9'h001; want_s.nfp = 9'h002;
    cyc(1'b0, 1'b0, 9'h002);
    hold(2, 9'h002);
    cyc(1'b0, 1'b1, 9'h002);
    rst_exp(3'd5);
    cyc(1'b1, 1'b0, 9'h002);
    cyc(1'b0, 1'b0, 9'h000);
    want_s.gs = 2'b01; want_s.nfp = 9'h001; want_s.gold = 9'h002;
    cyc(1'b0, 1'b1, 9'h000);
    hold(1, 9'h000);

    // LIFE_MAX=1: first burn ends the game as a loss; start returns to INIT.
    sel_b = 1'b1;
    rst_exp(3'd1);
    cyc(1'b1, 1'b0, 9'h000);
    want_s.gs = 2'b01; want_s.nfp = 9'h001; want_s.gold = 9'h002;
    cyc(1'b0, 1'b1, 9'h000);
    hold(7, 9'h000);
    want_s.fire = 9'h001; want_s.nfp = 9'h002;
    cyc(1'b0, 1'b0, 9'h001);
    want_s = '0; want_s.gs = 2'b10;
    cyc(1'b0, 1'b0, 9'h001);
    hold(2, 9'h001);
    rst_exp(3'd1);
    cyc(1'b0, 1'b1, 9'h000);
    hold(2, 9'h000);

    // Score 2 and one life: fire hit and winning gold in the same cycle is a loss.
    two_gold_rounds(3'd1);
    hold(7, 9'h000);
    want_s.fire = 9'h004; want_s.nfp = 9'h008;
    cyc(1'b0, 1'b0, 9'h000);
    want_s = '0; want_s.gs = 2'b10; want_s.score = 4'd3;
    cyc(1'b0, 1'b0, 9'h005);
    hold(2, 9'h000);

    // Gold-only path to SCORE_MAX wins; restart keeps the advanced LFSR.
    sel_b = 1'b0;
    two_gold_rounds(3'd5);
    want_s = '0; want_s.gs = 2'b10; want_s.life = 3'd5; want_s.score = 4'd3; want_s.win = 1'b1;
    cyc(1'b0, 1'b0, 9'h001);
    hold(2, 9'h000);
    rst_exp(3'd5);
    cyc(1'b0, 1'b1, 9'h000);
    hold(2, 9'h000);
    want_s.gs = 2'b01; want_s.nfp = 9'h008; want_s.gold = 9'h001;
    cyc(1'b0, 1'b1, 9'h000);
    hold(2, 9'h000);

    check_eq("scoreboard drained", 9'(sb_q.size()), 9'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
